// File: rtl/sramlike_bus_arbiter.sv
// sramlike_bus_arbiter: shares one sram-like slave port between the instruction
// and data masters. One transaction is outstanding at a time. Each transaction
// is tracked from grant through addr_ok to data_ok, and its completion is routed
// back only to the master that owns it.
// Optional build macro: SRAMLIKE_ARB_RR_EN. When it is defined, the IDLE
// selection alternates (round-robin) between the two masters when both request.
// When it is undefined, data has fixed priority over inst.
module sramlike_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction master
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    // data master
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    // shared slave
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t cand;
    owner_t sel;
    logic   addr_hs;
    logic   done;

`ifdef SRAMLIKE_ARB_RR_EN
    owner_t last_grant_q, last_grant_d;

    // Candidate in IDLE: the master not granted last wins a tie.
    always_comb begin
        cand = OWN_NONE;
        if (data_req && inst_req) begin
            cand = (last_grant_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            cand = OWN_DATA;
        end else if (inst_req) begin
            cand = OWN_INST;
        end
    end
`else
    // Candidate in IDLE: data has fixed priority over inst.
    always_comb begin
        cand = OWN_NONE;
        if (data_req) begin
            cand = OWN_DATA;
        end else if (inst_req) begin
            cand = OWN_INST;
        end
    end
`endif

    // Active master: the live candidate in IDLE, the locked owner otherwise.
    assign sel = (state_q == ST_IDLE) ? cand : owner_q;

    // Forward the selected request group; with no selection it falls to data.
    always_comb begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
        if (sel == OWN_INST) begin
            bus_wr    = inst_wr;
            bus_size  = inst_size;
            bus_addr  = inst_addr;
            bus_wdata = inst_wdata;
        end
    end

    // Slave request and completion qualification; reset masks everything.
    always_comb begin
        bus_req = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus_req = (cand != OWN_NONE);
                done    = (cand != OWN_NONE) && bus_addr_ok && bus_data_ok;
            end
            ST_ADDR: begin
                bus_req = (owner_q == OWN_INST) ? inst_req : data_req;
                done    = bus_addr_ok && bus_data_ok;
            end
            ST_DATA: begin
                bus_req = 1'b0;
                done    = bus_data_ok;
            end
            default: begin
                bus_req = 1'b0;
                done    = 1'b0;
            end
        endcase
        if (rst) begin
            bus_req = 1'b0;
            done    = 1'b0;
        end
    end

    assign addr_hs = bus_req && bus_addr_ok;

    // Route handshakes only to the active master; read data is broadcast.
    assign inst_addr_ok = addr_hs && (sel == OWN_INST);
    assign data_addr_ok = addr_hs && (sel == OWN_DATA);
    assign inst_data_ok = done && (sel == OWN_INST);
    assign data_data_ok = done && (sel == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    // Next-state and owner logic for the IDLE/ADDR/DATA transaction tracker.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef SRAMLIKE_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cand != OWN_NONE) begin
`ifdef SRAMLIKE_ARB_RR_EN
                    last_grant_d = cand;
`endif
                    if (bus_addr_ok && bus_data_ok) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                    end else if (bus_addr_ok) begin
                        state_d = ST_DATA;
                        owner_d = cand;
                    end else begin
                        state_d = ST_ADDR;
                        owner_d = cand;
                    end
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok && bus_data_ok) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end else if (bus_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, owner and (optionally) last-grant registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
`ifdef SRAMLIKE_ARB_RR_EN
            last_grant_q <= OWN_INST;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef SRAMLIKE_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
// Scoreboard bench for sramlike_bus_arbiter: stimulus pushes the expected slave
// request groups and master completions; a negedge monitor pops and compares.
module tb_sramlike_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
`ifdef SRAMLIKE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]        inst_size = 2'd0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic [DATA_W-1:0] inst_wdata = '0;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_addr_ok, inst_data_ok;
    logic              data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]        data_size = 2'd0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_wdata = '0;
    logic [DATA_W-1:0] data_rdata;
    logic              data_addr_ok, data_data_ok;
    logic              bus_req, bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata = '0;
    logic              bus_addr_ok = 1'b0, bus_data_ok = 1'b0;

    typedef struct {
        bit          is_inst;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        bit          is_inst;
        logic [31:0] rdata;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];
    int checks = 0;
    int errors = 0;

    sramlike_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bus_exp_t mk_bus(input bit is_inst, input logic wr, input logic [1:0] size,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.is_inst = is_inst; e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    function automatic rsp_exp_t mk_rsp(input bit is_inst, input logic [31:0] rdata);
        rsp_exp_t r;
        r.is_inst = is_inst; r.rdata = rdata;
        return r;
    endfunction

    // Monitor: every accepted request and every completion is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req && bus_addr_ok) begin
                if (exp_bus.size() == 0) begin
                    chk("unexpected_addr_hs", 64'(bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    chk("bus_addr", 64'(bus_addr), 64'(e.addr));
                    chk("bus_ctrl", 64'({bus_wr, bus_size}), 64'({e.wr, e.size}));
                    if (e.wr) chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
                    chk("addr_ok_route", 64'({inst_addr_ok, data_addr_ok}),
                        e.is_inst ? 64'd2 : 64'd1);
                end
            end else if (inst_addr_ok || data_addr_ok) begin
                chk("addr_ok_without_hs", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
            end
            if (inst_data_ok || data_data_ok) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
                end else begin
                    rsp_exp_t r;
                    r = exp_rsp.pop_front();
                    chk("data_ok_route", 64'({inst_data_ok, data_data_ok}),
                        r.is_inst ? 64'd2 : 64'd1);
                    chk("rdata", r.is_inst ? 64'(inst_rdata) : 64'(data_rdata), 64'(r.rdata));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Two simultaneous requests: inst read and data write; 1-cycle addr_ok latency.
    task automatic do_pair(input bit inst_first, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] r1, input logic [31:0] r2);
        bus_exp_t ei, ed;
        ei = mk_bus(1'b1, 1'b0, 2'd2, ia, 32'h0);
        ed = mk_bus(1'b0, 1'b1, 2'd2, da, 32'h1234_5678);
        if (inst_first) begin
            exp_bus.push_back(ei); exp_bus.push_back(ed);
            exp_rsp.push_back(mk_rsp(1'b1, r1)); exp_rsp.push_back(mk_rsp(1'b0, r2));
        end else begin
            exp_bus.push_back(ed); exp_bus.push_back(ei);
            exp_rsp.push_back(mk_rsp(1'b0, r1)); exp_rsp.push_back(mk_rsp(1'b1, r2));
        end
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = ia; inst_wdata = 32'h0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = da;
        data_wdata = 32'h1234_5678;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(negedge clk);
        chk("pair_first_addr", 64'(bus_addr), inst_first ? 64'(ia) : 64'(da));
        chk("pair_first_wr", 64'(bus_wr), inst_first ? 64'd0 : 64'd1);
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0;
        if (inst_first) inst_req = 1'b0; else data_req = 1'b0;
        @(negedge clk);
        chk("pair_data_phase_req", 64'(bus_req), 64'd0);
        next_cycle();
        bus_data_ok = 1'b1; bus_rdata = r1;
        next_cycle();
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("pair_second_addr", 64'(bus_addr), inst_first ? 64'(da) : 64'(ia));
        chk("pair_second_req", 64'(bus_req), 64'd1);
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = r2;
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state; idle bus group falls through from the data master.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        data_addr = 32'h0000_ABCD;
        @(negedge clk);
        chk("reset_bus_req", 64'(bus_req), 64'd0);
        chk("reset_oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'd0);
        chk("idle_bus_addr_mux", 64'(bus_addr), 64'h0000_ABCD);
        next_cycle();

        // Single inst read: addr_ok at cycle 0, data_ok at cycle 2.
        exp_bus.push_back(mk_bus(1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0));
        exp_rsp.push_back(mk_rsp(1'b1, 32'h3C1D_0001));
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
        bus_addr_ok = 1'b1;
        next_cycle();
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        @(negedge clk);
        chk("single_data_phase_req", 64'(bus_req), 64'd0);
        next_cycle();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C1D_0001;
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();

        // First simultaneous pair: data wins (fixed priority, and the last grant was inst).
        do_pair(1'b0, 32'hBFC0_0004, 32'h8000_0010, 32'h0000_0000, 32'hAAAA_5555);

        // Grant lock: inst waits 3 cycles for addr_ok while data requests.
        exp_bus.push_back(mk_bus(1'b1, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0));
        exp_rsp.push_back(mk_rsp(1'b1, 32'h1111_2222));
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
        next_cycle();
        exp_bus.push_back(mk_bus(1'b0, 1'b0, 2'd1, 32'h8000_0200, 32'h0));
        exp_rsp.push_back(mk_rsp(1'b0, 32'h3333_4444));
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h8000_0200;
        @(negedge clk);
        chk("lock_bus_addr_c1", 64'(bus_addr), 64'hBFC0_0100);
        chk("lock_data_addr_ok", 64'(data_addr_ok), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("lock_bus_addr_c2", 64'(bus_addr), 64'hBFC0_0100);
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("lock_data_phase_req", 64'(bus_req), 64'd0);
        next_cycle();
        bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
        next_cycle();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; data_req = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h3333_4444;
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();

        // Same-cycle addr_ok + data_ok in IDLE for a data read.
        exp_bus.push_back(mk_bus(1'b0, 1'b0, 2'd2, 32'h8000_1000, 32'h0));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hCAFE_F00D));
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("same_cycle_oks", 64'({data_addr_ok, data_data_ok}), 64'd3);
        next_cycle();
        // Still IDLE: a stray data_ok must not reach anyone.
        data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        @(negedge clk);
        chk("same_cycle_stays_idle", 64'({inst_data_ok, data_data_ok}), 64'd0);
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();

        // Second simultaneous pair: last grant was data, so round-robin serves inst first.
        do_pair(RR, 32'hBFC0_0008, 32'h8000_0020, 32'h5555_0001, 32'h5555_0002);

        // Reset while waiting for data_ok abandons the transaction.
        exp_bus.push_back(mk_bus(1'b1, 1'b0, 2'd2, 32'hBFC0_0200, 32'h0));
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0200;
        bus_addr_ok = 1'b1;
        next_cycle();
        inst_req = 1'b0; bus_addr_ok = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'd0);
        chk("post_reset_bus_req", 64'(bus_req), 64'd0);
        next_cycle();
        bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
        next_cycle();
        bus_data_ok = 1'b0;
        next_cycle();

        chk("exp_bus_drained", 64'(exp_bus.size()), 64'd0);
        chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
